// File: rtl/serdes_8b10b_pkg.sv
// Shared 8b/10b tables, state encoding and symbol type for the serializer slice.
package serdes_8b10b_pkg;

  typedef logic [9:0] symbol_t;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } ser_state_t;

  // RD- codes; the RD+ form is derived in the encoder.
  localparam logic [5:0] ENC_5B6B [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  localparam logic [3:0] ENC_3B4B [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  localparam logic [3:0] A7_RDM_CODE = 4'b0111;

  localparam logic [4:0] A7_RDM_SET [3] = '{5'd17, 5'd18, 5'd20};
  localparam logic [4:0] A7_RDP_SET [3] = '{5'd11, 5'd13, 5'd14};

  function automatic logic is_balanced6(input logic [5:0] code);
    return ($countones(code) == 3);
  endfunction

  function automatic logic is_balanced4(input logic [3:0] code);
    return ($countones(code) == 2);
  endfunction

  // Alternate x.7 avoids a run of five equal bits across the 6b/4b boundary.
  function automatic logic use_a7(input logic rd, input logic [4:0] x);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((!rd && x == A7_RDM_SET[i]) || (rd && x == A7_RDP_SET[i])) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/enc_8b10b.sv
// Combinational 8b/10b encoder: byte plus running disparity in, symbol plus new disparity out.
module enc_8b10b
  import serdes_8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       rd_in,
  output logic [9:0] symbol,
  output logic       rd_out
);

  logic [5:0] code6;
  logic [3:0] code4;
  logic       unbal6;
  logic       unbal4;
  logic       rd_mid;

  // Balance is checked on the RD- form; complementing never changes it.
  always_comb begin
    code6  = ENC_5B6B[data[4:0]];
    unbal6 = !is_balanced6(code6);
    if (rd_in && (unbal6 || data[4:0] == 5'd7)) begin
      code6 = ~code6;
    end
    rd_mid = rd_in ^ unbal6;

    if (data[7:5] == 3'd7 && use_a7(rd_mid, data[4:0])) begin
      code4 = A7_RDM_CODE;
    end else begin
      code4 = ENC_3B4B[data[7:5]];
    end
    unbal4 = !is_balanced4(code4);
    if (rd_mid && (unbal4 || data[7:5] == 3'd3)) begin
      code4 = ~code4;
    end
    rd_out = rd_mid ^ unbal4;

    symbol = {code6, code4};
  end

endmodule

// File: rtl/serializer_8b10b.sv
// 8b/10b serializer: one-entry holding register feeding a 10-bit shifter, LSB sent first.
module serializer_8b10b
  import serdes_8b10b_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Serial,
  output logic       o_Bit_Valid,
  output logic       o_RD
);

  ser_state_t state;
  ser_state_t state_next;

  logic [9:0] hold_sym;
  logic       hold_valid;
  logic [9:0] shift_sym;
  logic [3:0] bit_cnt;
  logic       rd;

  logic       transfer;
  logic       load;
  logic       last_bit;
  logic [9:0] enc_sym;
  logic       enc_rd;

  enc_8b10b u_enc (
    .data   (i_Data),
    .rd_in  (rd),
    .symbol (enc_sym),
    .rd_out (enc_rd)
  );

  assign o_Ready  = !hold_valid;
  assign o_RD     = rd;
  assign transfer = i_Valid && !hold_valid;
  assign last_bit = (bit_cnt == 4'd9);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reload at bit 9 keeps back-to-back symbols gapless.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    o_Bit_Valid = 1'b0;
    o_Serial    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_valid) begin
          state_next = ST_SHIFT;
          load       = 1'b1;
        end
      end
      ST_SHIFT: begin
        o_Bit_Valid = 1'b1;
        o_Serial    = shift_sym[bit_cnt];
        if (last_bit) begin
          if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_sym   <= '0;
      hold_valid <= 1'b0;
      shift_sym  <= '0;
      bit_cnt    <= '0;
      rd         <= 1'b0;
    end else begin
      if (transfer) begin
        hold_sym   <= enc_sym;
        hold_valid <= 1'b1;
        rd         <= enc_rd;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (load) begin
        shift_sym <= hold_sym;
        bit_cnt   <= '0;
      end else if (state == ST_SHIFT) begin
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/serializer_8b10b.md
SERIALIZER_8B10B -- requirements
Module: serializer_8b10b

Interface
REQ-001 SHALL have no parameters; widths fixed (8-bit byte, 10-bit symbol).
REQ-002 i_Clk  input  1  single clock; all state on rising edge.
REQ-003 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_Data  input  8  byte to send; [4:0]=EDCBA (5b part), [7:5]=HGF (3b part).
REQ-005 i_Valid  input  1  i_Data valid this cycle.
REQ-006 o_Ready  output  1  block accepts i_Data this cycle.
REQ-007 o_Serial  output  1  serial bit, feeds deserializer-side FIFO data input.
REQ-008 o_Bit_Valid  output  1  o_Serial carries a symbol bit this cycle (FIFO write enable).
REQ-009 o_RD  output  1  current running disparity; 0=RD-, 1=RD+.

Function
REQ-010 Transfer SHALL occur on a rising edge where i_Valid && o_Ready; no other edge consumes i_Data.
REQ-011 o_Ready SHALL equal !hold_valid (one-entry holding register empty), with no combinational path from i_Valid.
REQ-012 On transfer, the byte SHALL be 8b/10b encoded with current RD into hold (10 bits), hold_valid set, o_RD updated to post-symbol RD, all at the same edge.
REQ-013 Symbol layout SHALL be [9:4]=6b code abcdei, [3:0]=4b code fghj.
REQ-014 6b code SHALL come from the standard 5b/6b RD- table; RD+ code is bitwise complement when the code is unbalanced or is D.7 (111000/000111); otherwise identical.
REQ-015 4b code SHALL use standard 3b/4b RD- table; RD+ complements when unbalanced or x.3 (1100/0011).
REQ-016 x.7 SHALL use A7 (0111 for RD-, 1000 for RD+) when RD-&&5b in {17,18,20} or RD+&&5b in {11,13,14}; otherwise P7 (1110/0001).
REQ-017 RD after 6b block SHALL flip iff 6b code unbalanced; 4b block evaluated with that intermediate RD; same flip rule.
REQ-018 FSM states IDLE, SHIFT; IDLE->SHIFT when hold_valid; SHIFT->IDLE after bit 9 when !hold_valid; SHIFT->SHIFT (reload) after bit 9 when hold_valid.
REQ-019 Load SHALL copy hold to shift register, clear bit counter to 0 and clear hold_valid, unless a transfer occurs on the same edge, in which case hold takes the new symbol and hold_valid stays 1.
REQ-020 In SHIFT, o_Serial SHALL be shift[counter], sent symbol bit 0 first through bit 9; counter increments each cycle.
REQ-021 o_Bit_Valid SHALL be 1 exactly in SHIFT; back-to-back symbols produce gapless bit stream.
REQ-022 In IDLE o_Serial SHALL be 0.
REQ-023 Latency: transfer at edge N -> first bit valid in cycle after edge N+1 (IDLE case).
REQ-024 Sustained throughput SHALL be one byte per 10 cycles; o_Ready low at most 9 cycles while shifter busy with hold full.

Reset
REQ-025 While i_Rst_n low (asynchronous), state SHALL be IDLE, hold_valid=0, counter=0, shift=0, o_RD=0, o_Ready=1, o_Bit_Valid=0, o_Serial=0.
REQ-026 Reset mid-symbol SHALL abort immediately; no remaining bits sent after release; held byte discarded.
REQ-027 First edge after release SHALL accept a byte if i_Valid=1.

Structure
REQ-028 Package serdes_8b10b_pkg SHALL hold the 5b/6b and 3b/4b RD- tables, A7 index sets, state enum, symbol typedef (10 bits).
REQ-029 Encoding SHALL live in one combinational sub-module enc_8b10b (byte, RD in -> symbol, RD out); serializer_8b10b holds hold/shift registers and FSM.

Verification
REQ-030 Reset, send 0x00 -> symbol 10'b1001110100, serial bits 0,0,1,0,1,1,1,0,0,1; o_RD=0 after.
REQ-031 Send 0x03 twice back-to-back -> 10'b1100011011 then 10'b1100010100; o_RD 1 then 0; 20 contiguous o_Bit_Valid cycles.
REQ-032 Send 0xF1 (D.17.7) from RD- -> A7 used, 4b=0111; 0xEB (D.11.7) from RD+ -> 4b=1000.
REQ-033 Hold i_Valid=1 for 5 bytes -> o_Ready pattern 1,0x9,1 repeating; no byte dropped or duplicated.
REQ-034 Assert i_Rst_n=0 at bit 4 of a symbol -> o_Bit_Valid falls same cycle, o_RD=0, next byte after release starts from bit 0.
REQ-035 Loopback through async_FIFO and deserializer -> o_Data equals all 256 sent bytes in order.
